// File: rtl/serial_frame_deframer_if.sv
// Bit-stream input and word-level output bundle of the serial frame deframer.
interface serial_frame_deframer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              bit_in;
  logic              bit_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              sync_lock;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output bit_in, bit_en,
    input  data_out, data_valid, sync_lock, frame_cnt
  );

  modport slave (
    input  bit_in, bit_en,
    output data_out, data_valid, sync_lock, frame_cnt
  );
endinterface

// File: rtl/serial_frame_deframer.sv
// Hunts a sliding sync word in a qualified serial stream, then assembles the
// following DATA_W bits MSB-first into a word with a one-cycle valid pulse.
module serial_frame_deframer #(
  parameter int unsigned       SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_frame_deframer_if.slave  bus
);
  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
  localparam int unsigned FILL_W = $clog2(SYNC_W + 1);

  typedef enum logic {HUNT, DATA} state_t;

  state_t              state_q, state_d;
  logic [SYNC_W-1:0]   sync_sr_q, sync_sr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   data_sr_q, data_sr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_q, valid_d;
  logic                lock_q, lock_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [SYNC_W-1:0]   sync_next;
  logic [DATA_W-1:0]   data_next;

  // Shifted candidates; the cast drops the oldest bit.
  assign sync_next = SYNC_W'({sync_sr_q, bus.bit_in});
  assign data_next = DATA_W'({data_sr_q, bus.bit_in});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      sync_sr_q  <= '0;
      fill_q     <= '0;
      bcnt_q     <= '0;
      data_sr_q  <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sync_sr_q  <= sync_sr_d;
      fill_q     <= fill_d;
      bcnt_q     <= bcnt_d;
      data_sr_q  <= data_sr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_sr_d  = sync_sr_q;
    fill_d     = fill_q;
    bcnt_d     = bcnt_q;
    data_sr_d  = data_sr_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    lock_d     = lock_q;
    cnt_d      = cnt_q;

    if (bus.bit_en) begin
      unique case (state_q)
        HUNT: begin
          sync_sr_d = sync_next;
          if (fill_q < FILL_W'(SYNC_W)) fill_d = FILL_W'(fill_q + 1'b1);
          // A match needs a full window of fresh bits since entering HUNT.
          if ((fill_q >= FILL_W'(SYNC_W - 1)) && (sync_next == SYNC_WORD)) begin
            state_d = DATA;
            lock_d  = 1'b1;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          data_sr_d = data_next;
          bcnt_d    = BCNT_W'(bcnt_q + 1'b1);
          if (bcnt_q == BCNT_W'(DATA_W - 1)) begin
            data_out_d = data_next;
            valid_d    = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = CNT_W'(cnt_q + 1'b1);
            state_d   = HUNT;
            lock_d    = 1'b0;
            sync_sr_d = '0;
            fill_d    = '0;
            bcnt_d    = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.sync_lock  = lock_q;
  assign bus.frame_cnt  = cnt_q;
endmodule
